// File: rtl/gpr_ctrl.sv
// rtl/gpr_ctrl.sv - register-file ALU command controller (IDLE/READ/EXEC/WRITE); optional saturation via GPR_CTRL_SAT_EN
module gpr_ctrl #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    output logic          rf_read_en,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          flag_z,
    output logic          flag_c
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    state_t        state, state_nxt;
    logic [1:0]    op_q;
    logic [DW-1:0] a_q, b_q;
    logic          accept;
    logic [DW:0]   sum, diff;
    logic [DW-1:0] alu_res;
    logic          alu_c;

    // Strobes are gated by reset so an abort in WRITE never reaches the register file.
    assign cmd_ready  = !reset && (state == IDLE);
    assign rf_read_en = !reset && (state == READ);
    assign rf_we      = !reset && (state == WRITE);
    assign done       = !reset && (state == WRITE);
    assign rf_wdata   = result;
    assign accept     = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = a_q;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[DW-1:0];
                alu_c   = sum[DW];
`ifdef GPR_CTRL_SAT_EN
                if (sum[DW]) alu_res = '1;
`endif
            end
            OP_SUB: begin
                alu_res = diff[DW-1:0];
                alu_c   = diff[DW];
`ifdef GPR_CTRL_SAT_EN
                if (diff[DW]) alu_res = '0;
`endif
            end
            OP_AND:  alu_res = a_q & b_q;
            default: alu_res = a_q;
        endcase
    end

    // The latched rs1/rs2/rd double as the read/write address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rf_raddr1 <= '0;
            rf_raddr2 <= '0;
            rf_waddr  <= '0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q      <= cmd_op;
                rf_raddr1 <= cmd_rs1;
                rf_raddr2 <= cmd_rs2;
                rf_waddr  <= cmd_rd;
            end
            if (state == READ) begin
                a_q <= rf_rdata1;
                b_q <= rf_rdata2;
            end
            if (state == EXEC) begin
                result <= alu_res;
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_gpr_ctrl.sv
// tb/tb_gpr_ctrl.sv - directed self-checking bench for gpr_ctrl with a behavioural register file
module tb_gpr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
    logic       rf_read_en, rf_we, done, flag_z, flag_c;
    logic [1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [7:0] rf_rdata1, rf_rdata2, rf_wdata, result;

    logic [7:0] rf [4];
    logic       pre_we = 1'b0;
    logic [1:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpr_ctrl #(.DW(8), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .rf_read_en(rf_read_en), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c)
    );

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        else if (pre_we) rf[pre_addr] <= pre_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick;
        pre_we = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [7:0] exp_r,
                           input logic exp_c, input logic exp_z);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        check("ready_idle", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_rd = ~rd; cmd_rs1 = ~rs1; cmd_rs2 = ~rs2;
        check("read_en", rf_read_en, 1);
        check("raddr1", rf_raddr1, rs1);
        check("raddr2", rf_raddr2, rs2);
        check("ready_busy", cmd_ready, 0);
        tick;
        check("exec_read_en", rf_read_en, 0);
        check("exec_we", rf_we, 0);
        tick;
        check("we", rf_we, 1);
        check("done", done, 1);
        check("waddr", rf_waddr, rd);
        check("wdata", rf_wdata, exp_r);
        check("result", result, exp_r);
        check("flag_c", flag_c, exp_c);
        check("flag_z", flag_z, exp_z);
        tick;
        check("post_we", rf_we, 0);
        check("post_done", done, 0);
        check("post_ready", cmd_ready, 1);
        check("rf_commit", rf[rd], exp_r);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        tick;
        tick;
        check("rst_ready", cmd_ready, 0);
        check("rst_read_en", rf_read_en, 0);
        check("rst_we", rf_we, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {flag_z, flag_c}, 0);
        check("rst_raddr", {rf_raddr1, rf_raddr2}, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1);

        preload(2'd1, 8'hF0);
        preload(2'd2, 8'h20);
`ifdef GPR_CTRL_SAT_EN
        run_cmd(2'b00, 2'd3, 2'd1, 2'd2, 8'hFF, 1'b1, 1'b0);
`else
        run_cmd(2'b00, 2'd3, 2'd1, 2'd2, 8'h10, 1'b1, 1'b0);
`endif

        preload(2'd1, 8'h05);
        preload(2'd2, 8'h05);
        run_cmd(2'b01, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0, 1'b1);
        preload(2'd1, 8'h03);
        preload(2'd2, 8'h04);
`ifdef GPR_CTRL_SAT_EN
        run_cmd(2'b01, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, 1'b1);
`else
        run_cmd(2'b01, 2'd3, 2'd1, 2'd2, 8'hFF, 1'b1, 1'b0);
`endif
        preload(2'd0, 8'h3C);
        run_cmd(2'b10, 2'd0, 2'd0, 2'd1, 8'h00, 1'b0, 1'b1);
        preload(2'd2, 8'hA7);
        run_cmd(2'b11, 2'd2, 2'd2, 2'd0, 8'hA7, 1'b0, 1'b0);

        // back-to-back MOV R0<-R1 then AND R2<-R0,R0 with valid held and inputs toggling
        preload(2'd1, 8'h5A);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rd = 2'd0; cmd_rs1 = 2'd1; cmd_rs2 = 2'd3;
        tick;
        cmd_op = 2'b00; cmd_rd = 2'd3; cmd_rs1 = 2'd2; cmd_rs2 = 2'd2;
        check("b2b_raddr1", rf_raddr1, 1);
        tick;
        cmd_op = 2'b01; cmd_rd = 2'd1; cmd_rs1 = 2'd3;
        check("b2b_exec_ready", cmd_ready, 0);
        tick;
        cmd_op = 2'b10; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0;
        check("b2b_done1", done, 1);
        check("b2b_waddr1", rf_waddr, 0);
        check("b2b_wdata1", rf_wdata, 8'h5A);
        tick;
        check("b2b_ready", cmd_ready, 1);
        check("b2b_r0", rf[0], 8'h5A);
        tick;
        cmd_op = 2'b00; cmd_rd = 2'd1; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1;
        check("b2b_read2", rf_read_en, 1);
        check("b2b_raddr2", {rf_raddr1, rf_raddr2}, 4'b0000);
        tick;
        check("b2b_exec2_done", done, 0);
        tick;
        check("b2b_done2", done, 1);
        check("b2b_waddr2", rf_waddr, 2);
        check("b2b_wdata2", rf_wdata, 8'h5A);
        check("b2b_flags2", {flag_z, flag_c}, 0);
        cmd_valid = 1'b0;
        tick;
        check("b2b_r2", rf[2], 8'h5A);
        check("b2b_r1_kept", rf[1], 8'h5A);

        // reset during EXEC aborts the command
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 2'd1; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1;
        tick;
        cmd_valid = 1'b0;
        tick;
        reset = 1'b1;
        #1;
        check("exec_rst_ready", cmd_ready, 0);
        tick;
        check("exec_rst_we", rf_we, 0);
        check("exec_rst_done", done, 0);
        check("exec_rst_result", result, 0);
        check("exec_rst_addrs", {rf_raddr1, rf_raddr2, rf_waddr}, 0);
        tick;
        check("exec_rst_we2", rf_we, 0);
        reset = 1'b0;
        #1;
        check("exec_rst_release_ready", cmd_ready, 1);
        tick;
        check("exec_rst_r1", rf[1], 8'h5A);
        check("exec_rst_idle", cmd_ready, 1);

        // reset during WRITE suppresses the write strobe
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 2'd1; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        check("wr_rst_we", rf_we, 0);
        check("wr_rst_done", done, 0);
        tick;
        check("wr_rst_r1", rf[1], 8'h5A);
        check("wr_rst_wdata", rf_wdata, 0);
        reset = 1'b0;
        #1;
        check("wr_rst_ready", cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_ctrl.md
GPR_CTRL -- requirements
Module: gpr_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8, setting the data width of the register-file data ports and result.
REQ-002 The block SHALL have parameter AW, default 2, setting the width of the register address.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 MOV.
REQ-008 cmd_rd / cmd_rs1 / cmd_rs2  input  AW each  destination and source register addresses.
REQ-009 rf_read_en  output  1  read enable to register file.
REQ-010 rf_raddr1 / rf_raddr2  output  AW each  read addresses.
REQ-011 rf_rdata1 / rf_rdata2  input  DW each  combinational read data from the register file, valid while rf_read_en=1.
REQ-012 rf_we  output  1  register-file write strobe.
REQ-013 rf_waddr  output  AW  write address.
REQ-014 rf_wdata  output  DW  write data.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 result  output  DW  last computed result.
REQ-017 flag_z / flag_c  output  1 each  zero flag and carry/borrow flag of the last operation.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, EXEC and WRITE, with transitions IDLE->READ on accept, READ->EXEC, EXEC->WRITE and WRITE->IDLE, one cycle each.
REQ-019 cmd_ready SHALL be 1 only in IDLE with reset=0; an accept occurs when cmd_valid=1 and cmd_ready=1 at a posedge.
REQ-020 On accept, op, rd, rs1 and rs2 SHALL be latched; later changes on the cmd_* inputs are ignored until the next accept.
REQ-021 In READ, rf_read_en SHALL be 1, rf_raddr1 SHALL equal rs1 and rf_raddr2 SHALL equal rs2; rf_rdata1 and rf_rdata2 are captured at the end of READ.
REQ-022 rf_read_en SHALL be 0 in every state other than READ; rf_raddr1 and rf_raddr2 hold their last values.
REQ-023 In EXEC, result, flag_z and flag_c SHALL be computed and registered at the end of the cycle.
REQ-024 ADD SHALL produce a DW+1-bit sum, with result = low DW bits and flag_c = bit DW.
REQ-025 SUB SHALL produce result = rs1-rs2 modulo 2^DW, with flag_c = 1 if rs2 > rs1 (borrow).
REQ-026 AND SHALL produce the bitwise AND with flag_c = 0; MOV SHALL produce result = rs1 with flag_c = 0.
REQ-027 flag_z SHALL be 1 if and only if the final result, after any saturation, is 0.
REQ-028 In WRITE, rf_we SHALL be 1, rf_waddr SHALL equal rd, rf_wdata SHALL equal result, and done SHALL be 1; rf_we and done SHALL be 0 in every other state.
REQ-029 Latency SHALL be: accept at cycle N, write and done at cycle N+3, cmd_ready again at N+4.
REQ-030 The write SHALL commit at the end of cycle N+3, so a back-to-back command that reads rd at cycle N+5 obtains the new value; no bypass is required.
REQ-031 rd equal to rs1 or rs2 SHALL be legal; the sources are read before the write.
REQ-032 cmd_valid=1 while cmd_ready=0 SHALL have no effect.

Reset
REQ-033 With reset=1 at a posedge, the FSM SHALL enter IDLE and result, flag_z, flag_c, rf_raddr1, rf_raddr2, rf_waddr and rf_wdata SHALL all be cleared to 0.
REQ-034 While reset=1, rf_read_en, rf_we, done and cmd_ready SHALL be 0.
REQ-035 A reset asserted in any state, including WRITE, SHALL abort the command with no register-file write in that cycle.
REQ-036 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-037 With GPR_CTRL_SAT_EN defined, ADD with carry SHALL give result = all ones, and SUB with borrow SHALL give result = 0; flag_c SHALL still report the carry or borrow.
REQ-038 Without GPR_CTRL_SAT_EN, ADD and SUB results SHALL wrap modulo 2^DW.

Verification
REQ-039 Reset mid-EXEC: assert reset in EXEC -> no rf_we pulse, all outputs 0, cmd_ready=1 one cycle after release.
REQ-040 ADD, R1=0xF0, R2=0x20, rd=R3 -> rf_we at N+3 with waddr=3, wdata=0x10 (0xFF when GPR_CTRL_SAT_EN is defined), flag_c=1, flag_z=0.
REQ-041 SUB, R1=0x05, R2=0x05 -> result 0x00, flag_z=1, flag_c=0; then SUB 0x03-0x04 -> result 0xFF (0x00 when GPR_CTRL_SAT_EN is defined) with flag_c=1.
REQ-042 Back-to-back: MOV R0<-R1 (R1=0x5A), then AND R2<-R0,R0 with cmd_valid held high -> second accept at N+4, wdata=0x5A, done pulses at N+3 and N+7.
REQ-043 cmd_valid held high and cmd_* inputs toggled during READ, EXEC and WRITE -> the latched command executes unchanged and exactly one accept occurs per four cycles.
